// File: rtl/mult_sched_pkg.sv
// mult_sched_pkg: shared types and sizing helpers for the shared multiplier
// scheduler.
//   state_e  : scheduler FSM states
//   *_DEF    : default operand widths / requester count
//   id_w()   : width of a requester index (at least 1 bit)
package mult_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int N_DEF    = 8;
  localparam int M_DEF    = 8;
  localparam int NREQ_DEF = 4;

  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int ID_W_DEF = id_w(NREQ_DEF);

endpackage

// File: rtl/mult_shift_add_core.sv
// mult_shift_add_core: iterative unsigned shift-add multiplier, one bit of b
// per clock.
//   clk, reset  : clock, async active-low reset
//   load        : latch a/b and start a new product (ignored state is lost)
//   a, b        : operands (N and M bits)
//   done        : high from the edge the last iteration completes until the
//                 next load
//   product     : accumulator, valid while done is high
// Build option: MULT_SCHED_EARLY_TERM_EN stops iterating as soon as the
// remaining multiplier bits are all zero (minimum one iteration).
module mult_shift_add_core #(
  parameter int N = 8,
  parameter int M = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [N-1:0]     a,
  input  logic [M-1:0]     b,
  output logic             done,
  output logic [N+M-1:0]   product
);

  localparam int CW = $clog2(M + 1);

  logic [N+M-1:0] acc_q, acc_d, a_sh_q, a_sh_d;
  logic [M-1:0]   b_sh_q, b_sh_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           run_q, run_d, done_q, done_d;
  logic           last;

  always_comb begin
    acc_d  = acc_q;
    a_sh_d = a_sh_q;
    b_sh_d = b_sh_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = done_q;
    last   = 1'b0;
    if (load) begin
      acc_d  = '0;
      a_sh_d = {{M{1'b0}}, a};
      b_sh_d = b;
      cnt_d  = CW'(M);
      run_d  = 1'b1;
      done_d = 1'b0;
    end else if (run_q) begin
      if (b_sh_q[0]) acc_d = acc_q + a_sh_q;
      a_sh_d = a_sh_q << 1;
      b_sh_d = b_sh_q >> 1;
      cnt_d  = cnt_q - CW'(1);
`ifdef MULT_SCHED_EARLY_TERM_EN
      // nothing left to add once the shifted multiplier is empty
      last   = (cnt_q == CW'(1)) || (b_sh_d == '0);
`else
      last   = (cnt_q == CW'(1));
`endif
      run_d  = ~last;
      done_d = last;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q  <= '0;
      a_sh_q <= '0;
      b_sh_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done    = done_q;
  assign product = acc_q;

endmodule

// File: rtl/mult_share_sched.sv
// mult_share_sched: round-robin scheduler sharing one shift-add multiplier
// between NREQ requesters, one job in flight.
//   clk, reset          : clock, async active-low reset
//   req_valid/req_ready : per-requester job handshake (ready one-hot, IDLE only)
//   req_a, req_b        : packed operands, slice i belongs to requester i
//   rsp_valid/rsp_ready : per-requester result handshake (valid one-hot)
//   rsp_data            : N+M bit unsigned product, held while rsp_valid
//   busy                : FSM not in IDLE
//   grant_id            : index of the current or most recent grant
// Build option: MULT_SCHED_EARLY_TERM_EN (see mult_shift_add_core).
module mult_share_sched
  import mult_sched_pkg::*;
#(
  parameter  int N    = N_DEF,
  parameter  int M    = M_DEF,
  parameter  int NREQ = NREQ_DEF,
  localparam int ID_W = id_w(NREQ)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*N-1:0]   req_a,
  input  logic [NREQ*M-1:0]   req_b,
  output logic [NREQ-1:0]     rsp_valid,
  input  logic [NREQ-1:0]     rsp_ready,
  output logic [N+M-1:0]      rsp_data,
  output logic                busy,
  output logic [ID_W-1:0]     grant_id
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d, gid_q, gid_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [N+M-1:0]    rsp_data_q, rsp_data_d;

  logic              found;
  logic [ID_W-1:0]   win;
  logic              load;
  logic              core_done;
  logic [N+M-1:0]    product;
  logic [N-1:0]      a_sel;
  logic [M-1:0]      b_sel;

  // first valid requester starting at rr_ptr, wrapping modulo NREQ
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
        found = 1'b1;
        win   = ID_W'((int'(rr_ptr_q) + k) % NREQ);
      end
    end
  end

  assign a_sel = req_a[int'(win)*N +: N];
  assign b_sel = req_b[int'(win)*M +: M];

  // gated by reset so ready is low immediately while reset is held
  assign load      = (state_q == IDLE) && found && reset;
  assign req_ready = load ? (NREQ'(1) << win) : '0;

  mult_shift_add_core #(.N(N), .M(M)) u_core (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .a       (a_sel),
    .b       (b_sel),
    .done    (core_done),
    .product (product)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gid_d       = gid_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          gid_d   = win;
          state_d = RUN;
        end
      end
      RUN: begin
        if (core_done) begin
          state_d     = DONE;
          rsp_valid_d = NREQ'(1) << gid_q;
          rsp_data_d  = product;
        end
      end
      DONE: begin
        // only the granted requester's ready bit matters
        if (rsp_ready[gid_q]) begin
          state_d     = IDLE;
          rsp_valid_d = '0;
          // pointer moves past the served requester only on completion
          rr_ptr_d    = (gid_q == ID_W'(NREQ - 1)) ? '0 : gid_q + ID_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gid_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gid_q       <= gid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != IDLE);
  assign grant_id  = gid_q;

endmodule

// File: tb/tb_mult_share_sched.sv
// tb_mult_share_sched: table of single jobs, directed multi-cycle sequences
// and random traffic, all checked against a transaction-level model.
module tb_mult_share_sched;

  localparam int N    = 8;
  localparam int M    = 8;
  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*N-1:0]   req_a;
  logic [NREQ*M-1:0]   req_b;
  logic [N+M-1:0]      rsp_data;
  logic                busy;
  logic [ID_W-1:0]     grant_id;

  mult_share_sched #(.N(N), .M(M), .NREQ(NREQ)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // edges from acceptance to first visible rsp_valid
  function automatic int lat_of(input logic [M-1:0] b);
`ifdef MULT_SCHED_EARLY_TERM_EN
    int bl;
    bl = 0;
    for (int i = 0; i < M; i++) if (b[i]) bl = i + 1;
    return ((bl == 0) ? 1 : bl) + 1;
`else
    return M + 1;
`endif
  endfunction

  // ---------------- transaction-level reference model ----------------
  bit     m_busy = 0;
  int     m_gid = 0, m_last_gid = 0, m_rr = 0, m_vld_at = 0;
  longint m_prod = 0;
  int     grant_log[$];
  longint prod_log[$];

  always @(negedge clk) begin : mon
    int w;
    if (!reset) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data",  rsp_data,  0);
      chk("rst_busy",      busy,      0);
      chk("rst_grant_id",  grant_id,  0);
      m_busy = 0; m_rr = 0; m_last_gid = 0;
    end else if (!m_busy) begin
      w = -1;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && req_valid[(m_rr + k) % NREQ]) w = (m_rr + k) % NREQ;
      chk("idle_req_ready", req_ready, (w < 0) ? 0 : (1 << w));
      chk("idle_rsp_valid", rsp_valid, 0);
      chk("idle_busy",      busy,      0);
      chk("idle_grant_id",  grant_id,  m_last_gid);
      if (w >= 0) begin
        m_busy     = 1;
        m_gid      = w;
        m_last_gid = w;
        m_prod     = longint'(req_a[w*N +: N]) * longint'(req_b[w*M +: M]);
        m_vld_at   = cyc + 1 + lat_of(req_b[w*M +: M]);
        grant_log.push_back(w);
      end
    end else begin
      chk("busy_flag",      busy,      1);
      chk("busy_req_ready", req_ready, 0);
      chk("busy_grant_id",  grant_id,  m_gid);
      if (cyc < m_vld_at) begin
        chk("run_rsp_valid", rsp_valid, 0);
      end else begin
        chk("done_rsp_valid", rsp_valid, 1 << m_gid);
        chk("done_rsp_data",  rsp_data,  m_prod);
        if (rsp_ready[m_gid]) begin
          m_busy = 0;
          m_rr   = (m_gid + 1) % NREQ;
          prod_log.push_back(m_prod);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_job(input int i, input int a, input int b);
    req_a[i*N +: N] = N'(a);
    req_b[i*M +: M] = M'(b);
  endtask

  task automatic wait_idle(input string nm);
    int c;
    c = 0;
    @(negedge clk);
    while ((busy || m_busy) && c < 300) begin
      @(negedge clk);
      c++;
    end
    chk(nm, busy, 0);
    tick();
  endtask

  task automatic wait_grants(input int n, input string nm);
    int c;
    c = 0;
    while (grant_log.size() < n && c < 300) begin
      @(negedge clk);
      c++;
    end
    chk(nm, grant_log.size() >= n, 1);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  typedef struct {
    int     id;
    int     a;
    int     b;
    longint prod;
    int     lat;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int acc, got, c;
    logic [NREQ-1:0] hs;

`ifdef MULT_SCHED_EARLY_TERM_EN
    tbl[0] = '{0,  13,  11,   143, 5};
    tbl[1] = '{1, 255, 255, 65025, 9};
    tbl[2] = '{2,   0,  77,     0, 8};
    tbl[3] = '{3, 200,   1,   200, 2};
    tbl[4] = '{0,   1, 128,   128, 9};
    tbl[5] = '{1,   0,   0,     0, 2};
    tbl[6] = '{2, 255,   1,   255, 2};
`else
    tbl[0] = '{0,  13,  11,   143, 9};
    tbl[1] = '{1, 255, 255, 65025, 9};
    tbl[2] = '{2,   0,  77,     0, 9};
    tbl[3] = '{3, 200,   1,   200, 9};
    tbl[4] = '{0,   1, 128,   128, 9};
    tbl[5] = '{1,   0,   0,     0, 9};
    tbl[6] = '{2, 255,   1,   255, 9};
`endif

    reset = 1'b0; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();

    // --- single-job table: latency and product ---
    foreach (tbl[v]) begin
      set_job(tbl[v].id, tbl[v].a, tbl[v].b);
      req_valid[tbl[v].id] = 1'b1;
      acc = -1; c = 0;
      while (acc < 0 && c < 50) begin
        @(negedge clk);
        if (req_ready[tbl[v].id]) acc = cyc + 1;
        c++;
      end
      chk("tbl_accept", acc >= 0, 1);
      tick();
      req_valid[tbl[v].id] = 1'b0;
      got = -1; c = 0;
      while (got < 0 && c < 50) begin
        @(negedge clk);
        if (rsp_valid[tbl[v].id]) got = cyc;
        c++;
      end
      chk("tbl_latency", got - acc, tbl[v].lat);
      chk("tbl_product", rsp_data, tbl[v].prod);
      tick();
      rsp_ready[tbl[v].id] = 1'b1;
      tick();
      rsp_ready = '0;
      wait_idle("tbl_busy_low");
    end

    // --- all four at once from rr_ptr=0 ---
    pulse_reset();
    tick();
    grant_log.delete(); prod_log.delete();
    for (int i = 0; i < NREQ; i++) set_job(i, i + 1, 10);
    req_valid = '1; rsp_ready = '1;
    c = 0;
    while (prod_log.size() < 4 && c < 200) begin
      @(negedge clk);
      hs = req_ready & req_valid;
      tick();
      req_valid &= ~hs;
      c++;
    end
    chk("all4_done", prod_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("all4_grant_order", (grant_log.size() > i) ? grant_log[i] : -1, i);
      chk("all4_product", (prod_log.size() > i) ? prod_log[i] : -1, (i + 1) * 10);
    end
    wait_idle("all4_idle");

    // --- fairness: 0 and 2 held continuously ---
    grant_log.delete();
    set_job(0, 3, 5); set_job(2, 7, 9);
    req_valid = 4'b0101;
    wait_grants(4, "fair_grants");
    tick();
    req_valid = '0;
    wait_idle("fair_idle");
    for (int i = 0; i < 4; i++)
      chk("fair_alternate", (grant_log.size() > i) ? grant_log[i] : -1, (i % 2) * 2);

    // --- response backpressure on requester 1 ---
    grant_log.delete();
    set_job(1, 255, 255); set_job(0, 2, 2);
    rsp_ready = 4'b1101;
    req_valid = 4'b0010;
    wait_grants(1, "bp_grant1");
    tick();
    req_valid = 4'b0001;
    got = -1; c = 0;
    while (got < 0 && c < 50) begin
      @(negedge clk);
      if (rsp_valid[1]) got = cyc;
      c++;
    end
    chk("bp_rsp_seen", got >= 0, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid_held", rsp_valid, 4'b0010);
      chk("bp_data_held",  rsp_data,  16'hFE01);
      chk("bp_no_grant",   req_ready, 0);
    end
    tick();
    rsp_ready = '1;
    wait_grants(2, "bp_grant2");
    tick();
    req_valid = '0;
    wait_idle("bp_idle");
    chk("bp_next_grant", (grant_log.size() > 1) ? grant_log[1] : -1, 0);

    // --- reset in the middle of RUN ---
    grant_log.delete(); prod_log.delete();
    set_job(2, 4, 6);
    req_valid = 4'b0100;
    wait_grants(1, "mid_prep");
    tick();
    req_valid = '0;
    wait_idle("mid_prep_idle");
    set_job(1, 9, 9); set_job(3, 11, 3);
    req_valid = 4'b1010;
    wait_grants(2, "mid_grant3");
    chk("mid_grant_from_ptr3", (grant_log.size() > 1) ? grant_log[1] : -1, 3);
    tick();
    req_valid = 4'b0010;
    tick(); tick(); tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_busy",      busy,      0);
    chk("mid_rst_req_ready", req_ready, 0);
    chk("mid_rst_grant_id",  grant_id,  0);
    chk("mid_rst_rsp_data",  rsp_data,  0);
    grant_log.delete();
    tick(); tick();
    reset = 1'b1;
    wait_grants(1, "mid_regrant");
    chk("mid_regrant_id", (grant_log.size() > 0) ? grant_log[0] : -1, 1);
    tick();
    req_valid = '0;
    wait_idle("mid_idle");
    chk("mid_no_stale_count", prod_log.size(), 2);
    chk("mid_regrant_product", (prod_log.size() > 1) ? prod_log[1] : -1, 81);

    // --- random traffic against the model ---
    for (int i = 0; i < 600; i++) begin
      req_valid = NREQ'($urandom);
      req_a     = ($urandom % 4 == 0) ? '0 : (NREQ*N)'($urandom);
      req_b     = (NREQ*M)'($urandom) >> ($urandom_range(0, 7));
      rsp_ready = NREQ'($urandom);
      tick();
    end
    req_valid = '0; rsp_ready = '1;
    wait_idle("rand_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
